// File: rtl/fft_stage_controller.sv
// fft_stage_controller
// Walks one shared radix-2 butterfly unit through every butterfly of an
// in-place N-point decimation-in-time FFT (N = 2**LOG2N).  Samples are
// already in bit-reversed order in RAM.  For each butterfly the controller
// issues a read of both legs with the matching twiddle index.  It then
// raises bf_new_input and waits for bf_ready before writing both legs back
// to the addresses it read from.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start        pulse, begins a transform when idle (ignored while busy)
//   bf_ready     butterfly result ready, only looked at while waiting
//   busy         high from start acceptance until done / error abort
//   done         one-cycle pulse after the last write-back
//   error        sticky wait-timeout flag, cleared by the next accepted start
//   rd_en        RAM read strobe for both legs
//   rd_addr_a/b  upper / lower leg read addresses
//   wr_en        RAM write strobe for both legs
//   wr_addr_a/b  upper / lower leg write addresses
//   twiddle_num  twiddle index (4 bits) to the butterfly
//   bf_new_input new-input flag to the butterfly
//   stage        current stage, for status / debug
module fft_stage_controller #(
    parameter int LOG2N   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bf_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [3:0]       twiddle_num,
    output logic             bf_new_input,
    output logic [2:0]       stage
);

    localparam int JW = LOG2N - 1;            // butterfly index width (N/2 butterflies)
    localparam int CW = $clog2(TIMEOUT + 1);  // wait counter width

    localparam logic [2:0]       S_LAST = 3'(LOG2N - 1);
    localparam logic [JW-1:0]    J_LAST = {JW{1'b1}};
    localparam logic [JW-1:0]    J_ZERO = {JW{1'b0}};
    localparam logic [JW-1:0]    J_ONE  = JW'(32'd1);
    localparam logic [CW-1:0]    W_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]    W_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    W_ONE  = CW'(32'd1);
    localparam logic [LOG2N-1:0] ONE_A  = LOG2N'(32'd1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [2:0]        s_r, s_s;
    logic [JW-1:0]     j_r, j_s;
    logic [CW-1:0]     wcnt_r, wcnt_s;

    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              error_r, error_s;
    logic              rd_en_r, rd_en_s;
    logic              wr_en_r, wr_en_s;
    logic              bf_new_r, bf_new_s;
    logic [LOG2N-1:0]  rd_addr_a_r, rd_addr_a_s;
    logic [LOG2N-1:0]  rd_addr_b_r, rd_addr_b_s;
    logic [LOG2N-1:0]  wr_addr_a_r, wr_addr_a_s;
    logic [LOG2N-1:0]  wr_addr_b_r, wr_addr_b_s;
    logic [3:0]        tw_r, tw_s;
    logic [2:0]        stage_r, stage_s;

    // Address generation for the butterfly that is about to be read.
    logic [LOG2N-1:0]  j_ext_s, h_s, pos_s, grp_s, addr_a_s, addr_b_s;
    logic [3:0]        tw_calc_s;

    // FSM next state, loop counters and next values of the control outputs.
    always_comb begin
        state_s  = state_r;
        s_s      = s_r;
        j_s      = j_r;
        wcnt_s   = wcnt_r;
        busy_s   = busy_r;
        error_s  = error_r;
        done_s   = 1'b0;
        rd_en_s  = 1'b0;
        wr_en_s  = 1'b0;
        bf_new_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    error_s = 1'b0;
                    busy_s  = 1'b1;
                    s_s     = 3'd0;
                    j_s     = J_ZERO;
                    rd_en_s = 1'b1;
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                bf_new_s = 1'b1;
                wcnt_s   = W_ZERO;
                state_s  = ST_WAIT;
            end
            ST_WAIT: begin
                if (bf_ready) begin
                    // Dropping bf_new_input here also resets the butterfly's
                    // internal counter for the next operand pair.
                    wr_en_s = 1'b1;
                    state_s = ST_WRITE;
                end else if (wcnt_r == W_LAST) begin
                    error_s = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    wcnt_s   = wcnt_r + W_ONE;
                    bf_new_s = 1'b1;
                end
            end
            ST_WRITE: begin
                if (j_r == J_LAST) begin
                    j_s = J_ZERO;
                    if (s_r == S_LAST) begin
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        s_s     = s_r + 3'd1;
                        rd_en_s = 1'b1;
                        state_s = ST_READ;
                    end
                end else begin
                    j_s     = j_r + J_ONE;
                    rd_en_s = 1'b1;
                    state_s = ST_READ;
                end
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                s_s     = 3'd0;
                j_s     = J_ZERO;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Leg addresses and twiddle from the next stage / butterfly counters:
    // h = 2**s, pos = j mod h, grp = j / h, a = grp*2h + pos, b = a + h.
    always_comb begin
        j_ext_s   = {1'b0, j_s};
        h_s       = ONE_A << s_s;
        pos_s     = j_ext_s & (h_s - ONE_A);
        grp_s     = j_ext_s >> s_s;
        addr_a_s  = (grp_s << (s_s + 3'd1)) + pos_s;
        addr_b_s  = addr_a_s + h_s;
        tw_calc_s = 4'(pos_s) << (S_LAST - s_s);
    end

    // Next values of the address outputs: reads latch new addresses, writes
    // reuse the addresses of the butterfly just read, otherwise hold.
    always_comb begin
        if (rd_en_s) begin
            rd_addr_a_s = addr_a_s;
            rd_addr_b_s = addr_b_s;
            tw_s        = tw_calc_s;
        end else begin
            rd_addr_a_s = rd_addr_a_r;
            rd_addr_b_s = rd_addr_b_r;
            tw_s        = tw_r;
        end
        if (wr_en_s) begin
            wr_addr_a_s = rd_addr_a_r;
            wr_addr_b_s = rd_addr_b_r;
        end else begin
            wr_addr_a_s = wr_addr_a_r;
            wr_addr_b_s = wr_addr_b_r;
        end
        stage_s = s_s;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            s_r         <= 3'd0;
            j_r         <= J_ZERO;
            wcnt_r      <= W_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            rd_en_r     <= 1'b0;
            wr_en_r     <= 1'b0;
            bf_new_r    <= 1'b0;
            rd_addr_a_r <= {LOG2N{1'b0}};
            rd_addr_b_r <= {LOG2N{1'b0}};
            wr_addr_a_r <= {LOG2N{1'b0}};
            wr_addr_b_r <= {LOG2N{1'b0}};
            tw_r        <= 4'd0;
            stage_r     <= 3'd0;
        end else begin
            state_r     <= state_s;
            s_r         <= s_s;
            j_r         <= j_s;
            wcnt_r      <= wcnt_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
            rd_en_r     <= rd_en_s;
            wr_en_r     <= wr_en_s;
            bf_new_r    <= bf_new_s;
            rd_addr_a_r <= rd_addr_a_s;
            rd_addr_b_r <= rd_addr_b_s;
            wr_addr_a_r <= wr_addr_a_s;
            wr_addr_b_r <= wr_addr_b_s;
            tw_r        <= tw_s;
            stage_r     <= stage_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign rd_en        = rd_en_r;
    assign wr_en        = wr_en_r;
    assign bf_new_input = bf_new_r;
    assign rd_addr_a    = rd_addr_a_r;
    assign rd_addr_b    = rd_addr_b_r;
    assign wr_addr_a    = wr_addr_a_r;
    assign wr_addr_b    = wr_addr_b_r;
    assign twiddle_num  = tw_r;
    assign stage        = stage_r;

endmodule

// File: tb/tb_fft_stage_controller.sv
// Directed testbench for fft_stage_controller: a 16-point instance driven by
// a simple butterfly responder, plus a 4-point instance for the small build.
module tb_fft_stage_controller;

    logic       clk, rst_n;
    logic       start, bf_ready;
    logic       busy, done, error, rd_en, wr_en, bf_new_input;
    logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, twiddle_num;
    logic [2:0] stage;

    logic       start2, bf_ready2;
    logic       busy2, done2, error2, rd_en2, wr_en2, bf_new_input2;
    logic [1:0] rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;
    logic [3:0] twiddle_num2;
    logic [2:0] stage2;

    fft_stage_controller #(.LOG2N(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bf_ready(bf_ready),
        .busy(busy), .done(done), .error(error), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .twiddle_num(twiddle_num),
        .bf_new_input(bf_new_input), .stage(stage)
    );

    fft_stage_controller #(.LOG2N(2), .TIMEOUT(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bf_ready(bf_ready2),
        .busy(busy2), .done(done2), .error(error2), .rd_en(rd_en2),
        .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .wr_en(wr_en2),
        .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2), .twiddle_num(twiddle_num2),
        .bf_new_input(bf_new_input2), .stage(stage2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vecs = 0;
    int errs = 0;

    // run bookkeeping
    int edges, nrd, nwr, ndone, done_edge, last_wr_edge, overlap, busy_low;
    int nrd2, done2_edge;
    int mode;      // 0: ready 5 cycles into WAIT, 1: ready stuck high, 2: ready stuck low
    int wcnt;
    bit in_run;
    logic [3:0] ra [32];
    logic [3:0] rb [32];
    logic [3:0] rtw[32];
    logic [1:0] ra2[4];
    logic [1:0] rb2[4];
    logic [3:0] rtw2[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {addr_a, addr_b, twiddle} for 16 points: addr_a is the j-th
    // index whose bit s is clear; its partner differs only in bit s.
    function automatic logic [11:0] model(input int s, input int j);
        int h, cnt, a, b, tw;
        h = 1 << s;
        cnt = 0;
        a = 0;
        for (int i = 0; i < 16; i++) begin
            if ((i & h) == 0) begin
                if (cnt == j) a = i;
                cnt++;
            end
        end
        b = a + h;
        tw = (a % h) << (3 - s);
        return {a[3:0], b[3:0], tw[3:0]};
    endfunction

    function automatic void clear_run();
        edges = 0; nrd = 0; nwr = 0; ndone = 0; done_edge = -1;
        last_wr_edge = -1; overlap = 0; busy_low = 0; wcnt = 0;
        nrd2 = 0; done2_edge = -1;
    endfunction

    // One clock: observe outputs just after the edge, then update the responder.
    task automatic tick();
        logic [11:0] m;
        @(posedge clk);
        #1;
        edges++;
        if (rd_en && wr_en) overlap++;
        if (in_run && !busy) busy_low++;
        if (rd_en) begin
            if (nrd < 32) begin
                m = model(nrd / 8, nrd % 8);
                chk("rd_addr_tw", {20'd0, rd_addr_a, rd_addr_b, twiddle_num}, {20'd0, m});
                chk("rd_stage", {29'd0, stage}, nrd / 8);
                ra[nrd] = rd_addr_a;
                rb[nrd] = rd_addr_b;
                rtw[nrd] = twiddle_num;
            end
            nrd++;
        end
        if (bf_new_input && nrd > 0 && nrd <= 32) begin
            m = model((nrd - 1) / 8, (nrd - 1) % 8);
            chk("wait_hold", {20'd0, rd_addr_a, rd_addr_b, twiddle_num}, {20'd0, m});
        end
        if (wr_en) begin
            if (nwr < 32) begin
                m = model(nwr / 8, nwr % 8);
                chk("wr_addr", {24'd0, wr_addr_a, wr_addr_b}, {24'd0, m[11:4]});
            end
            last_wr_edge = edges;
            nwr++;
        end
        if (done) begin
            ndone++;
            done_edge = edges;
        end
        if (rd_en2) begin
            if (nrd2 < 4) begin
                ra2[nrd2] = rd_addr_a2;
                rb2[nrd2] = rd_addr_b2;
                rtw2[nrd2] = twiddle_num2;
            end
            nrd2++;
        end
        if (done2) done2_edge = edges;
        if (bf_new_input) wcnt++;
        else wcnt = 0;
        if (mode == 1) bf_ready = 1'b1;
        else if (mode == 2) bf_ready = 1'b0;
        else bf_ready = (bf_new_input && wcnt >= 5);
    endtask

    initial begin
        logic [1:0] ea2[4];
        logic [1:0] eb2[4];
        logic [3:0] et2[4];
        ea2 = '{2'd0, 2'd2, 2'd0, 2'd1};
        eb2 = '{2'd1, 2'd3, 2'd2, 2'd3};
        et2 = '{4'd0, 4'd0, 4'd0, 4'd1};

        rst_n = 1'b0; start = 1'b0; bf_ready = 1'b0; start2 = 1'b0; bf_ready2 = 1'b0;
        mode = 0; in_run = 1'b0;
        clear_run();

        // reset state
        repeat (3) @(posedge clk);
        #3;
        chk("reset_outs", {3'd0, busy, done, error, rd_en, wr_en, bf_new_input, stage,
            rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, twiddle_num}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_outs", {3'd0, busy, done, error, rd_en, wr_en, bf_new_input, stage,
            rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, twiddle_num}, 32'd0);

        // full 16-point run, ready 5 cycles into WAIT, stray start mid-run
        clear_run();
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        in_run = 1'b1;
        for (int c = 0; c < 400 && done_edge < 0; c++) begin
            if (c == 50) start = 1'b1;
            tick();
            start = 1'b0;
        end
        in_run = 1'b0;
        chk("run_done_edge", done_edge, 225);
        chk("run_last_wr", last_wr_edge, 224);
        chk("run_writes", nwr, 32);
        chk("run_reads", nrd, 32);
        chk("run_done_count", ndone, 1);
        chk("run_busy_low", busy_low, 0);
        chk("run_rd_wr_overlap", overlap, 0);
        chk("s0j0", {20'd0, ra[0], rb[0], rtw[0]}, 32'h016 & 32'h010);
        chk("s1j1", {20'd0, ra[9], rb[9], rtw[9]}, 32'h134);
        chk("s2j3", {20'd0, ra[19], rb[19], rtw[19]}, 32'h376);
        chk("s3j5", {20'd0, ra[29], rb[29], rtw[29]}, 32'h5d5);
        chk("s1j2", {20'd0, ra[10], rb[10], rtw[10]}, 32'h460);
        tick();
        chk("after_done", {30'd0, busy, done}, 32'd0);

        // reset asserted mid-WAIT
        clear_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pre_reset_wait", {31'd0, bf_new_input}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", {3'd0, busy, done, error, rd_en, wr_en, bf_new_input, stage,
            rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, twiddle_num}, 32'd0);
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        nwr = 0;
        repeat (20) tick();
        chk("post_reset_writes", nwr, 0);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        // WAIT timeout with ready stuck low
        clear_run();
        mode = 2;
        bf_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        chk("to_last_wait", {29'd0, error, busy, bf_new_input}, 32'b011);
        tick();
        chk("to_abort", {29'd0, error, busy, bf_new_input}, 32'b100);
        chk("to_writes", nwr, 0);
        repeat (3) tick();
        chk("to_sticky", {31'd0, error}, 32'd1);

        // restart with ready stuck high: error clears, 3 cycles per butterfly
        clear_run();
        mode = 1;
        bf_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_clear", {30'd0, error, busy}, 32'b01);
        in_run = 1'b1;
        for (int c = 0; c < 200 && done_edge < 0; c++) tick();
        in_run = 1'b0;
        chk("fast_done_edge", done_edge, 97);
        chk("fast_writes", nwr, 32);
        chk("fast_error", {31'd0, error}, 32'd0);
        chk("fast_busy_low", busy_low, 0);
        chk("fast_overlap", overlap, 0);

        // 4-point build
        mode = 0;
        bf_ready = 1'b0;
        clear_run();
        bf_ready2 = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 0; c < 40 && done2_edge < 0; c++) tick();
        chk("n4_reads", nrd2, 4);
        chk("n4_done_edge", done2_edge, 13);
        for (int k = 0; k < 4; k++) begin
            chk("n4_addr_tw", {24'd0, ra2[k], rb2[k], rtw2[k]}, {24'd0, ea2[k], eb2[k], et2[k]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
